// File: rtl/branch_flag_unit_pkg.sv
// branch_flag_unit_pkg: shared FSM encoding and branch func3 constants so the
// controller and the flag unit agree on what zero/pos mean.
package branch_flag_unit_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_CMP, ST_DONE} state_t;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero, input logic pos);
        return f3 == F3_BEQ ? zero :
               f3 == F3_BNE ? !zero :
               f3 == F3_BLT ? !zero && !pos :
               f3 == F3_BGE ? zero || pos : 1'b0;
    endfunction
endpackage

// File: rtl/branch_chunk_cmp.sv
// branch_chunk_cmp: CHUNK-bit unsigned eq/gt; inv_msb_i flips both MSBs so the
// top chunk of a signed operand orders as two's complement.
module branch_chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] ca_i,
    input  logic [CHUNK-1:0] cb_i,
    input  logic             inv_msb_i,
    output logic             eq_o,
    output logic             gt_o
);
    logic [CHUNK-1:0] flip, xa, xb;
    always_comb begin
        flip = {inv_msb_i, {(CHUNK-1){1'b0}}};
        xa   = ca_i ^ flip;
        xb   = cb_i ^ flip;
        eq_o = xa == xb;
        gt_o = xa > xb;
    end
endmodule

// File: rtl/branch_flag_unit.sv
// branch_flag_unit: multi-cycle MSB-first chunked compare producing zero/pos,
// exiting early on the first differing chunk.
module branch_flag_unit import branch_flag_unit_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_cmp,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             pos
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] TOP = IW'(NCHUNK - 1);

    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sgn_q, busy_q, done_q, zero_q, pos_q;
    logic             eq, gt;

    // Operands shift left on each equal chunk, so the active chunk is always the top one.
    branch_chunk_cmp #(.CHUNK(CHUNK)) u_cmp (
        .ca_i      (a_q[WIDTH-1 -: CHUNK]),
        .cb_i      (b_q[WIDTH-1 -: CHUNK]),
        .inv_msb_i (sgn_q && idx_q == TOP),
        .eq_o      (eq),
        .gt_o      (gt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            pos_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (start) begin
                    a_q     <= a;
                    b_q     <= b;
                    sgn_q   <= signed_cmp;
                    idx_q   <= TOP;
                    busy_q  <= 1'b1;
                    state_q <= ST_CMP;
                end
                ST_CMP: if (!eq || idx_q == '0) begin
                    zero_q  <= eq;
                    pos_q   <= !eq && gt;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end else begin
                    idx_q <= idx_q - IW'(1);
                    a_q   <= a_q << CHUNK;
                    b_q   <= b_q << CHUNK;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign zero = zero_q;
    assign pos  = pos_q;
endmodule

// File: tb/tb_branch_flag_unit.sv
// tb_branch_flag_unit: directed vectors pushed to a scoreboard; a negedge
// monitor pops and checks zero/pos/latency on every done pulse.
module tb_branch_flag_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        signed_cmp = 1'b0;
    logic        busy, done, zero, pos;

    typedef struct {
        logic  z;
        logic  p;
        int    cyc;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    branch_flag_unit #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .signed_cmp(signed_cmp), .busy(busy), .done(done), .zero(zero), .pos(pos)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_zero"}, int'(zero), int'(e.z));
                chk({e.name, "_pos"}, int'(pos), int'(e.p));
                chk({e.name, "_latency"}, cyc, e.cyc);
            end
        end
    end

    // Call just after a posedge; drives start for one cycle.
    task automatic issue(input string name, input logic [31:0] va, input logic [31:0] vb,
                         input logic s, input logic z, input logic p, input int lat);
        #1;
        a = va;
        b = vb;
        signed_cmp = s;
        start = 1'b1;
        sb.push_back('{z: z, p: p, cyc: cyc + lat, name: name});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            chk({name, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_zero", int'(zero), 0);
        chk("reset_pos", int'(pos), 0);
        rst = 1'b0;
        @(posedge clk);
        issue("t1_eq", 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 5);
        chk("t1_busy", int'(busy), 1);
        drain("t1");
        issue("t2_unsigned_top", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 2);
        drain("t2");
        issue("t3_signed_top", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 2);
        drain("t3");
        issue("t4_signed_chunk2", 32'hFFFF_FF00, 32'hFFFF_FEFF, 1'b1, 1'b0, 1'b1, 4);
        drain("t4");
        issue("t7_signed_pos_neg", 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 2);
        drain("t7");
        issue("t8_unsigned_small_big", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 2);
        drain("t8");
        // start held high through CMP and DONE with new operands must be ignored
        issue("t5_ignore_start", 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 5);
        @(posedge clk);
        #1;
        a = 32'hFFFF_FFFF;
        b = 32'h0;
        start = 1'b1;
        repeat (4) @(posedge clk);
        #1 start = 1'b0;
        chk("t5_idle_after", int'(busy), 0);
        drain("t5");
        issue("t9_eq_again", 32'hCAFE_0001, 32'hCAFE_0001, 1'b1, 1'b1, 1'b0, 5);
        drain("t9");
        // reset mid-compare after two chunks: no done, outputs cleared at once
        #1;
        a = 32'h1234_5678;
        b = 32'h1234_5679;
        signed_cmp = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_done", int'(done), 0);
        chk("t6_rst_zero", int'(zero), 0);
        chk("t6_rst_pos", int'(pos), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        issue("t6_after_rst", 32'h1234_5678, 32'h1234_5679, 1'b0, 1'b0, 1'b0, 5);
        drain("t6");
        repeat (8) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
